// File: rtl/key_filter_pkg.sv
// Shared types and constants for the push-button filter and its helpers.
// The FSM state encoding is fixed so other blocks can decode it if needed.
package key_filter_pkg;

    localparam int CNT_W = 26;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        DOWN      = 2'd2,
        REL_DEB   = 2'd3
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// RST_VAL lets the caller park the output at the input's idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= RST_VAL;
            q        <= RST_VAL;
        end else begin
            meta_reg <= d;
            q        <= meta_reg;
        end
    end

endmodule

// File: rtl/key_filter_fsm.sv
// Push-button debouncer: synchronises key_in, confirms press/release after a
// CNT_MAX-cycle stable window and emits single-cycle press/release/long pulses.
module key_filter_fsm
    import key_filter_pkg::*;
#(
    parameter int   CNT_MAX    = 999_999,
    parameter int   LONG_MAX   = 49_999_999,
    parameter logic KEY_ACTIVE = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_rel,
    output logic key_long,
    output logic key_state
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MAX - 1);

    logic             key_s;
    logic             pressed;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             long_done_reg, long_done_next;
    logic             key_flag_next, key_rel_next, key_long_next, key_state_next;

    sync_2ff #(
        .RST_VAL (~KEY_ACTIVE)
    ) u_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (key_in),
        .q   (key_s)
    );

    assign pressed = (key_s == KEY_ACTIVE);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            long_done_reg <= 1'b0;
            key_flag      <= 1'b0;
            key_rel       <= 1'b0;
            key_long      <= 1'b0;
            key_state     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            long_done_reg <= long_done_next;
            key_flag      <= key_flag_next;
            key_rel       <= key_rel_next;
            key_long      <= key_long_next;
            key_state     <= key_state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = sat_inc(cnt_reg);
        long_done_next = long_done_reg;
        key_flag_next  = 1'b0;
        key_rel_next   = 1'b0;
        key_long_next  = 1'b0;
        key_state_next = key_state;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (pressed) begin
                    state_next = PRESS_DEB;
                end
            end

            PRESS_DEB: begin
                if (!pressed) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next     = DOWN;
                    cnt_next       = '0;
                    key_flag_next  = 1'b1;
                    key_state_next = 1'b1;
                end
            end

            DOWN: begin
                if (!pressed) begin
                    state_next = REL_DEB;
                    cnt_next   = '0;
                end else if (long_done_reg) begin
                    cnt_next = cnt_reg;
                end else if (cnt_reg == LONG_LAST) begin
                    // Freeze the count so the long pulse cannot repeat this press.
                    cnt_next       = cnt_reg;
                    key_long_next  = 1'b1;
                    long_done_next = 1'b1;
                end
            end

            REL_DEB: begin
                if (pressed) begin
                    // Release bounce: back to DOWN with the press still owned.
                    state_next = DOWN;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next     = IDLE;
                    cnt_next       = '0;
                    key_rel_next   = 1'b1;
                    key_state_next = 1'b0;
                    long_done_next = 1'b0;
                end
            end

            default: begin
                state_next     = IDLE;
                cnt_next       = '0;
                long_done_next = 1'b0;
                key_state_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_filter_fsm.sv
// Directed bench for key_filter_fsm with a short debounce window; pulse
// counts and edge indices are compared against hand-computed values.
module tb_key_filter_fsm;

    localparam int CNT_MAX  = 20;
    localparam int LONG_MAX = 100;
    localparam int LAT      = CNT_MAX + 3;  // drive edge -> pulse-visible edge

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_in  = 1'b1;
    logic key_flag, key_rel, key_long, key_state;

    int vec_cnt = 0;
    int err_cnt = 0;
    int edge_cnt = 0;
    int flag_cnt = 0, rel_cnt = 0, long_cnt = 0, overlap_cnt = 0;
    int flag_edge = -1, rel_edge = -1, long_edge = -1;
    int rise_edge = -1, fall_edge = -1;
    logic state_d = 1'b0;
    int base;

    key_filter_fsm #(
        .CNT_MAX    (CNT_MAX),
        .LONG_MAX   (LONG_MAX),
        .KEY_ACTIVE (1'b0)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key_in    (key_in),
        .key_flag  (key_flag),
        .key_rel   (key_rel),
        .key_long  (key_long),
        .key_state (key_state)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (key_flag) begin flag_cnt++; flag_edge = edge_cnt; end
        if (key_rel)  begin rel_cnt++;  rel_edge  = edge_cnt; end
        if (key_long) begin long_cnt++; long_edge = edge_cnt; end
        if (key_flag && key_rel) overlap_cnt++;
        if (key_state && !state_d) rise_edge = edge_cnt;
        if (!key_state && state_d) fall_edge = edge_cnt;
        state_d = key_state;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #25;
        check_val("rst_flag",  32'(key_flag),  0);
        check_val("rst_rel",   32'(key_rel),   0);
        check_val("rst_long",  32'(key_long),  0);
        check_val("rst_state", 32'(key_state), 0);
        check_val("rst_fsm",   32'(dut.state_reg), 0);
        tick(1);
        sys_rst = 1'b0;
        tick(5);

        // clean press, held long enough for a long pulse
        base = edge_cnt;
        key_in = 1'b0;
        tick(300);
        check_val("clean_flag_cnt",  flag_cnt, 1);
        check_val("clean_flag_edge", flag_edge, base + LAT);
        check_val("clean_state_rise", rise_edge, base + LAT);
        check_val("clean_long_cnt",  long_cnt, 1);
        check_val("clean_long_edge", long_edge, base + LAT + LONG_MAX);
        check_val("clean_level",     32'(key_state), 1);
        check_val("clean_no_rel",    rel_cnt, 0);

        base = edge_cnt;
        key_in = 1'b1;
        tick(40);
        check_val("clean_rel_cnt",   rel_cnt, 1);
        check_val("clean_rel_edge",  rel_edge, base + LAT);
        check_val("clean_state_fall", fall_edge, base + LAT);
        check_val("clean_level_off", 32'(key_state), 0);

        // bouncy press: 5-cycle toggles, then stable low
        for (int i = 0; i < 12; i++) begin
            key_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(5);
        end
        check_val("bounce_no_flag", flag_cnt, 1);
        base = edge_cnt;
        key_in = 1'b0;
        tick(30);
        check_val("bounce_flag_cnt",  flag_cnt, 2);
        check_val("bounce_flag_edge", flag_edge, base + LAT);
        key_in = 1'b1;
        tick(40);
        check_val("bounce_rel_cnt", rel_cnt, 2);

        // short glitch
        key_in = 1'b0;
        tick(10);
        key_in = 1'b1;
        tick(40);
        check_val("glitch_flag_cnt", flag_cnt, 2);
        check_val("glitch_level",    32'(key_state), 0);
        check_val("glitch_fsm_idle", 32'(dut.state_reg), 0);
        check_val("glitch_rel_cnt",  rel_cnt, 2);

        // release bounce
        key_in = 1'b0;
        tick(30);
        check_val("relb_flag_cnt", flag_cnt, 3);
        key_in = 1'b1;
        tick(8);
        key_in = 1'b0;
        tick(10);
        check_val("relb_glitch_no_rel", rel_cnt, 2);
        check_val("relb_level_held",    32'(key_state), 1);
        base = edge_cnt;
        key_in = 1'b1;
        tick(40);
        check_val("relb_rel_cnt",   rel_cnt, 3);
        check_val("relb_rel_edge",  rel_edge, base + LAT);
        check_val("relb_no_reflag", flag_cnt, 3);
        check_val("relb_no_long",   long_cnt, 1);

        // reset while DOWN, key kept pressed through reset release
        key_in = 1'b0;
        tick(30);
        check_val("rstmid_flag_cnt", flag_cnt, 4);
        check_val("rstmid_level_on", 32'(key_state), 1);
        #5;
        sys_rst = 1'b1;
        #1;
        check_val("rstmid_level_off", 32'(key_state), 0);
        check_val("rstmid_fsm_idle",  32'(dut.state_reg), 0);
        tick(3);
        sys_rst = 1'b0;
        base = edge_cnt;
        tick(30);
        check_val("rstmid_flag_again", flag_cnt, 5);
        check_val("rstmid_flag_edge",  flag_edge, base + LAT);
        check_val("rstmid_no_rel",     rel_cnt, 3);
        key_in = 1'b1;
        tick(40);
        check_val("rstmid_rel_cnt", rel_cnt, 4);

        check_val("flag_rel_overlap", overlap_cnt, 0);
        check_val("long_total",       long_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/key_filter_fsm.md
Name: key_filter_fsm

Overview:
- Debounces one mechanical push-button and emits clean one-cycle event pulses.
- Sits directly upstream of the SPI flash command controllers (sector erase, page program, read). Its key_flag output drives their key_flag input, so one physical press issues exactly one flash command.
- Also provides a debounced level, a release pulse and a long-press pulse for board-level UI.

Parameters:
- CNT_MAX, 999_999: debounce window in sys_clk cycles (20 ms at 50 MHz). Must be ≥ 2.
- LONG_MAX, 49_999_999: cycles held in DOWN before key_long fires (1 s at 50 MHz). Must be ≥ 1.
- KEY_ACTIVE, 1'b0: key_in level that means "pressed" (board keys are active-low).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst  input  1  reset, asynchronous, active-high.
- key_in   input  1  raw button, asynchronous to sys_clk, bouncing.
- key_flag output 1  one-cycle pulse on each confirmed press.
- key_rel  output 1  one-cycle pulse on each confirmed release.
- key_long output 1  one-cycle pulse once per press held ≥ LONG_MAX cycles.
- key_state output 1  debounced level, 1 = pressed.

Behaviour:
- Reset values: all outputs 0; state IDLE; cnt 0; both synchroniser flops hold the not-pressed level (~KEY_ACTIVE).
- Input path: key_in passes through a 2-flop synchroniser to give key_s. The FSM uses only key_s. "pressed" means key_s == KEY_ACTIVE.
- Counter cnt: one shared 26-bit counter, cleared on every state transition, saturating (never wraps).
- IDLE → PRESS_DEB when pressed. cnt = 0.
- PRESS_DEB:
  - Released → IDLE, cnt cleared. This is the bounce-reject path.
  - Pressed and cnt == CNT_MAX-1 → DOWN, with key_flag = 1 and key_state = 1 registered on the same edge.
  - Otherwise cnt + 1.
- DOWN:
  - Released → REL_DEB.
  - Otherwise cnt + 1 until it reaches LONG_MAX-1. On that edge key_long = 1 and a long_done bit is set. cnt then holds, so key_long fires at most once per press.
- REL_DEB:
  - Pressed → DOWN, without re-firing key_flag and without clearing long_done.
  - Released and cnt == CNT_MAX-1 → IDLE, with key_rel = 1, key_state = 0 and long_done cleared.
  - Otherwise cnt + 1.
- Latency: key_in stably pressed from sampling edge k gives key_flag high in the cycle after edge k+CNT_MAX+2. Release latency is symmetric: key_rel high after edge k+CNT_MAX+2.
- Pulse rules:
  - key_flag, key_rel and key_long are registered and high for exactly 1 cycle.
  - key_flag and key_rel never assert in the same cycle.
  - key_long may coincide with neither.
- Boundary cases:
  - Bounce shorter than CNT_MAX in either debounce state produces no pulse.
  - key_in held pressed through reset release produces one key_flag, CNT_MAX+2 cycles after reset deasserts.
  - Reset asserted mid-debounce or mid-DOWN clears everything immediately. No key_rel is generated for that press.
- Encoding: binary 2-bit state. Unused codes fall back to IDLE.

Decomposition:
- Package key_filter_pkg holds:
  - state encodings IDLE = 2'd0, PRESS_DEB = 2'd1, DOWN = 2'd2, REL_DEB = 2'd3;
  - counter width constant CNT_W = 26.
- One sub-module: sync_2ff (parameter RST_VAL). It is also reused by other blocks that take asynchronous inputs.

Test Plan:
All scenarios use CNT_MAX = 20, LONG_MAX = 100, KEY_ACTIVE = 0, 20 ns clock.
1. Clean press: key_in 1→0 at edge 50, held 300 cycles → key_flag high only in the cycle after edge 72; key_state = 1 from the same cycle; key_long pulses once, 100 cycles after entering DOWN.
2. Bouncy press: key_in toggles every 5 cycles for 60 cycles, then holds 0 → exactly one key_flag, 22 cycles after the final stable low; no pulse during bouncing.
3. Short glitch: key_in low for 10 cycles, then high → no key_flag, key_state stays 0, FSM back in IDLE.
4. Release bounce: from DOWN, key_in goes high for 8 cycles, then low again, then high steadily → no key_rel on the glitch, no second key_flag; exactly one key_rel 22 cycles after the final rise.
5. Reset mid-operation: sys_rst asserted 10 cycles into PRESS_DEB → all outputs 0 asynchronously. After deassert with key held low → one key_flag 22 cycles later.
6. Integration with flash sector-erase controller and m25p16 model: one press → exactly one sector-erase command sequence on cs_n/sck/mosi, no repeated command while the key is held.
